// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART telemetry frame packer.
// FRAME_CHECKSUM_EN adds a tenth byte (XOR checksum) ahead of CR LF.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAITB = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef logic [3:0] idx_t;

    localparam logic [7:0] CR_BYTE        = 8'h0D;
    localparam logic [7:0] LF_BYTE        = 8'h0A;
    localparam int         FRAME_LEN_BASE = 9;

`ifdef FRAME_CHECKSUM_EN
    localparam int   FRAME_LEN = FRAME_LEN_BASE + 1;
    // Checksum occupies the slot right after data[23:16]
    localparam idx_t CSUM_IDX  = 4'd7;
`else
    localparam int   FRAME_LEN = FRAME_LEN_BASE;
`endif

    localparam idx_t LAST_IDX = idx_t'(FRAME_LEN - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// Combinational selection of the frame byte for a given index from the snapshot.
// With FRAME_CHECKSUM_EN the checksum takes slot 7 and CR/LF move down by one.
module frame_byte_mux
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HDR0 = 8'h61,
    parameter logic [7:0] HDR1 = 8'h62
) (
    input  idx_t        idx,
    input  logic [15:0] temp,
    input  logic [23:0] word,
`ifdef FRAME_CHECKSUM_EN
    input  logic [7:0]  csum,
`endif
    output logic [7:0]  frame_byte
);

    // Index-to-byte lookup
    always_comb begin
        frame_byte = 8'h00;
        case (idx)
            4'd0:    frame_byte = HDR0;
            4'd1:    frame_byte = HDR1;
            4'd2:    frame_byte = temp[7:0];
            4'd3:    frame_byte = temp[15:8];
            4'd4:    frame_byte = word[7:0];
            4'd5:    frame_byte = word[15:8];
            4'd6:    frame_byte = word[23:16];
`ifdef FRAME_CHECKSUM_EN
            4'd7:    frame_byte = csum;
            4'd8:    frame_byte = CR_BYTE;
            4'd9:    frame_byte = LF_BYTE;
`else
            4'd7:    frame_byte = CR_BYTE;
            4'd8:    frame_byte = LF_BYTE;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/uart_frame_packer.sv
// Telemetry frame sequencer feeding async_transmitter one byte per TxD_start.
// Optional checksum byte is enabled by defining FRAME_CHECKSUM_EN.
module uart_frame_packer
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HDR0         = 8'h61,
    parameter logic [7:0] HDR1         = 8'h62,
    parameter int         GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic [15:0] temperature,
    input  logic [23:0] data,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [7:0]  overrun_cnt
);

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

    state_t      state_r;
    idx_t        idx_r;
    logic [3:0]  guard_cnt_r;
    logic [15:0] temp_r;
    logic [23:0] data_r;
    logic        tx_start_r;
    logic [7:0]  tx_data_r;
    logic        frame_busy_r;
    logic        frame_done_r;
    logic [7:0]  overrun_r;
    logic [7:0]  byte_s;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]  csum_r;
`endif

    frame_byte_mux #(
        .HDR0 (HDR0),
        .HDR1 (HDR1)
    ) u_mux (
        .idx        (idx_r),
        .temp       (temp_r),
        .word       (data_r),
`ifdef FRAME_CHECKSUM_EN
        .csum       (csum_r),
`endif
        .frame_byte (byte_s)
    );

    // Frame FSM with registered handshake outputs, snapshot and overrun counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 4'd0;
            guard_cnt_r  <= 4'd0;
            temp_r       <= 16'h0000;
            data_r       <= 24'h000000;
            tx_start_r   <= 1'b0;
            tx_data_r    <= 8'h00;
            frame_busy_r <= 1'b0;
            frame_done_r <= 1'b0;
            overrun_r    <= 8'h00;
`ifdef FRAME_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            tx_start_r   <= 1'b0;
            frame_done_r <= 1'b0;
            if (trigger && (state_r != ST_IDLE)) begin
                overrun_r <= sat_inc8(overrun_r);
            end
            case (state_r)
                ST_IDLE: begin
                    if (trigger) begin
                        temp_r       <= temperature;
                        data_r       <= data;
                        idx_r        <= 4'd0;
                        frame_busy_r <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        csum_r       <= 8'h00;
`endif
                        state_r      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_data_r <= byte_s;
                    state_r   <= ST_SEND;
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start_r  <= 1'b1;
                        guard_cnt_r <= 4'd0;
                        state_r     <= ST_GUARD;
`ifdef FRAME_CHECKSUM_EN
                        // Fold each byte ahead of the checksum slot as it goes out
                        if (idx_r < CSUM_IDX) begin
                            csum_r <= csum_r ^ tx_data_r;
                        end
`endif
                    end
                end
                ST_GUARD: begin
                    // The transmitter raises busy a cycle or so after the strobe
                    if (guard_cnt_r >= GUARD_LAST) begin
                        state_r <= ST_WAITB;
                    end else begin
                        guard_cnt_r <= guard_cnt_r + 4'd1;
                    end
                end
                ST_WAITB: begin
                    if (!tx_busy) begin
                        if (idx_r == LAST_IDX) begin
                            frame_done_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r + 4'd1;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    frame_busy_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    frame_busy_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign frame_busy  = frame_busy_r;
    assign frame_done  = frame_done_r;
    assign overrun_cnt = overrun_r;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer with a busy-stretching transmitter model and byte scoreboard.
// Build with FRAME_CHECKSUM_EN to exercise the 10-byte frame.
module tb_uart_frame_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] temperature = 16'h0000;
    logic [23:0] data = 24'h000000;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    int          tests_run = 0;
    int          fails = 0;
    int          stretch = 1;
    logic        stuck = 1'b0;
    int          busy_cnt;
    int          sent_cnt = 0;
    int          done_cnt = 0;
    logic        active = 1'b0;
    logic [7:0]  held;
    logic [7:0]  exp_byte;
    logic [7:0]  exp_q[$];

    uart_frame_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trigger     (trigger),
        .temperature (temperature),
        .data        (data),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
    );

    always #50 clk = ~clk;

    // Transmitter model: busy rises the cycle after tx_start and lasts 'stretch' cycles
    assign tx_busy = stuck | (busy_cnt != 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                busy_cnt <= 0;
        else if (tx_start)         busy_cnt <= stretch;
        else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
    end

    // Byte scoreboard and per-byte stability monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            active = 1'b0;
        end else begin
            if (frame_done) done_cnt++;
            if (tx_start) begin
                sent_cnt++;
                tests_run++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_byte observed=%h expected=<none>", tx_data);
                end
                if (exp_q.size() != 0) begin
                    exp_byte = exp_q.pop_front();
                    tests_run++;
                    assert (tx_data === exp_byte) else begin
                        fails++;
                        $error("FAIL byte_%0d observed=%h expected=%h", sent_cnt, tx_data, exp_byte);
                    end
                end
                held   = tx_data;
                active = 1'b1;
            end else if (active) begin
                if (tx_busy) begin
                    tests_run++;
                    assert (tx_data === held) else begin
                        fails++;
                        $error("FAIL tx_data_stable observed=%h expected=%h", tx_data, held);
                    end
                end else begin
                    active = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] t, input logic [23:0] d);
        logic [7:0] b[7];
        logic [7:0] cs;
        b[0] = 8'h61; b[1] = 8'h62; b[2] = t[7:0]; b[3] = t[15:8];
        b[4] = d[7:0]; b[5] = d[15:8]; b[6] = d[23:16];
        cs = 8'h00;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(b[i]);
            cs = cs ^ b[i];
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse_trigger();
        @(posedge clk); #1 trigger = 1'b1;
        @(posedge clk); #1 trigger = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != start), 32'd1);
        repeat (5) @(posedge clk);
        check({tag, "_one_done"}, 32'(done_cnt - start), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_frame_busy_low"}, 32'(frame_busy), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_frame_busy"}, 32'(frame_busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_overrun"}, 32'(overrun_cnt), 32'd0);
    endtask

    initial begin
        int base;
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // T1: fast busy, basic frame
        temperature = 16'h1234;
        data = 24'hABCDEF;
        stretch = 1;
        push_frame(16'h1234, 24'hABCDEF);
        base = sent_cnt;
        pulse_trigger();
        check("t1_busy_after_trigger", 32'(frame_busy), 32'd1);
        check("t1_no_early_start", 32'(sent_cnt - base), 32'd0);
        wait_frame("t1", 500);
        check("t1_overrun", 32'(overrun_cnt), 32'd0);

        // T3: slow transmitter, inputs change mid-frame
        stretch = 1000;
        temperature = 16'hBEEF;
        data = 24'h0155AA;
        push_frame(16'hBEEF, 24'h0155AA);
        pulse_trigger();
        #1 temperature = 16'h5A5A;
        data = 24'h123456;
        repeat (2500) @(posedge clk);
        #1 temperature = 16'hFFFF;
        data = 24'hFFFFFF;
        wait_frame("t3", 20000);

        // T4: dropped triggers during a frame
        stretch = 20;
        temperature = 16'h0F0F;
        data = 24'hC3C3C3;
        push_frame(16'h0F0F, 24'hC3C3C3);
        pulse_trigger();
        repeat (10) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            pulse_trigger();
            repeat (15) @(posedge clk);
        end
        wait_frame("t4a", 2000);
        check("t4a_overrun", 32'(overrun_cnt), 32'd3);

        stretch = 100;
        push_frame(16'h0F0F, 24'hC3C3C3);
        pulse_trigger();
        @(posedge clk); #1 trigger = 1'b1;
        repeat (300) @(posedge clk);
        #1 trigger = 1'b0;
        check("t4b_overrun_sat", 32'(overrun_cnt), 32'd255);
        wait_frame("t4b", 5000);
        check("t4b_overrun_hold", 32'(overrun_cnt), 32'd255);

        // T5: reset during byte 4
        stretch = 20;
        temperature = 16'h2468;
        data = 24'h13579B;
        push_frame(16'h2468, 24'h13579B);
        base = sent_cnt;
        pulse_trigger();
        n = 0;
        while (sent_cnt < base + 4 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("t5_reached_byte4", 32'(sent_cnt - base), 32'd4);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_idle_outputs("t5_async");
        @(posedge clk);
        #1 check_idle_outputs("t5_next");
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        push_frame(16'h2468, 24'h13579B);
        pulse_trigger();
        wait_frame("t5", 2000);

        // T6: busy stuck high at trigger
        stretch = 1;
        stuck = 1'b1;
        temperature = 16'h7E81;
        data = 24'h00FF00;
        push_frame(16'h7E81, 24'h00FF00);
        base = sent_cnt;
        pulse_trigger();
        repeat (50) @(posedge clk);
        #1 check("t6_no_start", 32'(sent_cnt - base), 32'd0);
        check("t6_frame_busy", 32'(frame_busy), 32'd1);
        stuck = 1'b0;
        wait_frame("t6", 500);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
